miss_req_sched: RTL

- Sequences retransmission re-requests for sequence-number gaps reported by miss_msg_det.
- Each gap event (sid, start, count) is buffered in a small FIFO.
- Gaps wider than the MoldUDP64 per-request message limit are split into consecutive chunks.
- Chunks are issued one at a time over a valid/ready handshake to the re-request packet builder, with a programmable hold-off between requests.

---
 rtl/moldudp64_pkg.sv | 22 ++
 rtl/miss_req_fifo.sv | 45 ++++
 rtl/miss_req_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/moldudp64_pkg.sv
// Shared MoldUDP64 re-request types: field widths, the gap-event record
// carried through the scheduler FIFO, and the scheduler FSM encoding.
package moldudp64_pkg;

  localparam int SEQ_NUM_W = 64;
  localparam int SID_W     = 80;
  localparam int ML_W      = 16;

  typedef struct packed {
    logic [SID_W-1:0]     sid;
    logic [SEQ_NUM_W-1:0] start;
    logic [SEQ_NUM_W-1:0] cnt;
  } gap_evt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    HOLD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/miss_req_fifo.sv
// Synchronous gap-event FIFO with full/empty flags. Push and pop in the same
// cycle are legal even when full: the read slot is consumed before the write
// lands, so the caller may push into a full FIFO whenever it also pops.
module miss_req_fifo
  import moldudp64_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     nreset,
  input  logic     push,
  input  gap_evt_t push_data,
  input  logic     pop,
  output gap_evt_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  gap_evt_t      mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_data = mem[rptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/miss_req_sched.sv
// Retransmission re-request scheduler. Buffers gap events, splits gaps wider
// than MAX_REQ_CNT into consecutive chunks, and issues one request at a time
// over valid/ready with a programmable hold-off after each accepted request.
// Optional build macro MISS_REQ_STATS_EN adds saturating request/drop counters.
module miss_req_sched
  import moldudp64_pkg::*;
#(
  parameter logic [ML_W-1:0] MAX_REQ_CNT = 16'hFFFF,
  parameter int              FIFO_D      = 4,
  parameter int              HOLDOFF_W   = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 req_v_o,
  input  logic                 req_ready_i,
  output logic [SID_W-1:0]     req_sid_o,
  output logic [SEQ_NUM_W-1:0] req_seq_num_o,
  output logic [ML_W-1:0]      req_cnt_o,
`ifdef MISS_REQ_STATS_EN
  output logic [31:0]          stat_req_o,
  output logic [31:0]          stat_drop_o,
`endif
  output logic                 busy_o,
  output logic                 ovf_o
);

  localparam logic [SEQ_NUM_W-1:0] MAX_REQ_W = {{(SEQ_NUM_W-ML_W){1'b0}}, MAX_REQ_CNT};

  sched_state_t          state;
  sched_state_t          state_nxt;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  gap_evt_t              fifo_in;
  gap_evt_t              fifo_out;
  logic                  evt_ok;
  logic                  evt_drop;
  logic                  hs;
  logic [SID_W-1:0]      wk_sid;
  logic [SEQ_NUM_W-1:0]  cur_seq;
  logic [SEQ_NUM_W-1:0]  rem_cnt;
  logic [HOLDOFF_W-1:0]  hold_cnt;
  logic [ML_W-1:0]       chunk_cnt;

  // Zero-length gaps are not events; a full FIFO only drops if nothing pops.
  assign evt_ok    = miss_v_i && (miss_cnt_i != '0);
  assign fifo_push = evt_ok && (!fifo_full || fifo_pop);
  assign evt_drop  = evt_ok && fifo_full && !fifo_pop;
  assign fifo_in   = '{sid: miss_sid_i, start: miss_start_i, cnt: miss_cnt_i};
  assign hs        = (state == REQ) && req_ready_i;
  // Compare at full sequence width so huge gaps never alias into a small chunk.
  assign chunk_cnt = (rem_cnt > MAX_REQ_W) ? MAX_REQ_CNT : rem_cnt[ML_W-1:0];

  miss_req_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and pop decision; HOLD expiry can pop directly to skip IDLE.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = REQ;
      REQ: begin
        if (req_ready_i) state_nxt = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (rem_cnt != '0) begin
            state_nxt = LOAD;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, request outputs and status flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      req_v_o       <= 1'b0;
      req_sid_o     <= '0;
      req_seq_num_o <= '0;
      req_cnt_o     <= '0;
      rem_cnt       <= '0;
      hold_cnt      <= '0;
      busy_o        <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= !fifo_empty || (state != IDLE);
      ovf_o  <= evt_drop;
      if (fifo_pop) rem_cnt <= fifo_out.cnt;
      if (state == LOAD) begin
        req_v_o       <= 1'b1;
        req_sid_o     <= wk_sid;
        req_seq_num_o <= cur_seq;
        req_cnt_o     <= chunk_cnt;
      end
      if (hs) begin
        req_v_o  <= 1'b0;
        rem_cnt  <= rem_cnt - {{(SEQ_NUM_W-ML_W){1'b0}}, req_cnt_o};
        hold_cnt <= holdoff_i;
      end else if ((state == HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Working session and cursor; cursor wraps modulo 2^SEQ_NUM_W by design.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      wk_sid  <= fifo_out.sid;
      cur_seq <= fifo_out.start;
    end else if (hs) begin
      cur_seq <= cur_seq + {{(SEQ_NUM_W-ML_W){1'b0}}, req_cnt_o};
    end
  end

`ifdef MISS_REQ_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Saturating counters of accepted requests and dropped events.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stat_req_o  <= '0;
      stat_drop_o <= '0;
    end else begin
      if (hs)       stat_req_o  <= sat_inc(stat_req_o);
      if (evt_drop) stat_drop_o <= sat_inc(stat_drop_o);
    end
  end
`endif

endmodule
